// File: rtl/collision_detector.sv
// collision_detector: checks each obstacle pixel against a hitbox at the cursor,
// then applies damage, a post-hit invulnerability window and game over.
module collision_detector #(
  parameter int CURSOR_W      = 16,
  parameter int CURSOR_H      = 16,
  parameter int HP_MAX        = 100,
  parameter int DAMAGE        = 10,
  parameter int INVULN_CYCLES = 65000000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic        vblank,
  input  logic        game_on,
  output logic        hit,
  output logic [7:0]  hp,
  output logic        invulnerable,
  output logic        game_over
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] INVULN = 2'd2;
  localparam logic [1:0] DEAD   = 2'd3;

  localparam logic [7:0]  HP_INIT  = 8'(HP_MAX);
  localparam logic [7:0]  DMG      = 8'(DAMAGE);
  localparam logic [26:0] INV_LAST = 27'(INVULN_CYCLES - 1);
  localparam logic [12:0] BOX_W    = 13'(CURSOR_W - 1);
  localparam logic [12:0] BOX_H    = 13'(CURSOR_H - 1);

  logic        vblank_d_q, vblank_d_d;
  logic [11:0] mx_l_q, mx_l_d;
  logic [11:0] my_l_q, my_l_d;
  logic        overlap_q, overlap_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  hp_q, hp_d;
  logic        hit_q, hit_d;
  logic [26:0] cnt_q, cnt_d;

  logic [12:0] x_hi, y_hi;
  logic        pix_valid;

  // Latch the cursor on the vblank rising edge and register the overlap test.
  always_comb begin
    vblank_d_d = vblank;
    mx_l_d     = mx_l_q;
    my_l_d     = my_l_q;
    if (vblank && !vblank_d_q) begin
      mx_l_d = mouse_x;
      my_l_d = mouse_y;
    end
    x_hi      = {1'b0, mx_l_q} + BOX_W;
    y_hi      = {1'b0, my_l_q} + BOX_H;
    pix_valid = (obstacle_x != 12'd0) || (obstacle_y != 12'd0);
    overlap_d = pix_valid
              && (obstacle_x >= mx_l_q)
              && ({1'b0, obstacle_x} <= x_hi)
              && (obstacle_y >= my_l_q)
              && ({1'b0, obstacle_y} <= y_hi);
  end

  // Session state machine: damage, invulnerability window and death.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        hp_d = HP_INIT;
        if (game_on) state_d = ARMED;
      end
      ARMED: begin
        if (!game_on) begin
          state_d = IDLE;
          hp_d    = HP_INIT;
        end else if (overlap_q) begin
          hit_d   = 1'b1;
          hp_d    = (hp_q > DMG) ? hp_q - DMG : 8'd0;
          cnt_d   = 27'd0;
          state_d = (hp_d == 8'd0) ? DEAD : INVULN;
        end
      end
      INVULN: begin
        if (!game_on) begin
          state_d = IDLE;
          hp_d    = HP_INIT;
          cnt_d   = 27'd0;
        end else if (cnt_q == INV_LAST) begin
          state_d = ARMED;
        end else begin
          cnt_d = cnt_q + 27'd1;
        end
      end
      DEAD: begin
        hp_d = 8'd0;
        if (!game_on) begin
          state_d = IDLE;
          hp_d    = HP_INIT;
        end
      end
    endcase
  end

  // Register update.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblank_d_q <= 1'b0;
      mx_l_q     <= 12'd0;
      my_l_q     <= 12'd0;
      overlap_q  <= 1'b0;
      state_q    <= IDLE;
      hp_q       <= HP_INIT;
      hit_q      <= 1'b0;
      cnt_q      <= 27'd0;
    end else begin
      vblank_d_q <= vblank_d_d;
      mx_l_q     <= mx_l_d;
      my_l_q     <= my_l_d;
      overlap_q  <= overlap_d;
      state_q    <= state_d;
      hp_q       <= hp_d;
      hit_q      <= hit_d;
      cnt_q      <= cnt_d;
    end
  end

  assign hit          = hit_q;
  assign hp           = hp_q;
  assign invulnerable = (state_q == INVULN);
  assign game_over    = (state_q == DEAD);

endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: two DUTs (HP 30 and HP 25) on shared stimulus,
// checked cycle by cycle against a timestamp-based reference model.
module tb_collision_detector;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] obstacle_x = '0, obstacle_y = '0;
  logic [11:0] mouse_x = '0, mouse_y = '0;
  logic        vblank = 1'b0, game_on = 1'b0;
  logic        hit0, inv0, go0, hit1, inv1, go1;
  logic [7:0]  hp0, hp1;

  collision_detector #(
    .CURSOR_W(16), .CURSOR_H(16), .HP_MAX(30),
    .DAMAGE(10), .INVULN_CYCLES(8)
  ) u_dut0 (
    .pclk(pclk), .rst(rst),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .vblank(vblank), .game_on(game_on),
    .hit(hit0), .hp(hp0),
    .invulnerable(inv0), .game_over(go0)
  );

  collision_detector #(
    .CURSOR_W(16), .CURSOR_H(16), .HP_MAX(25),
    .DAMAGE(10), .INVULN_CYCLES(8)
  ) u_dut1 (
    .pclk(pclk), .rst(rst),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .vblank(vblank), .game_on(game_on),
    .hit(hit1), .hp(hp1),
    .invulnerable(inv1), .game_over(go1)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int   tag;
    logic hit;
    logic [7:0] hp;
    logic inv;
    logic go;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;

  // Reference model: hitbox geometry with plain integers, damage and the
  // invulnerability window expressed as cycle timestamps.
  localparam int INV = 8;
  localparam int DMGV = 10;
  int  hpm[2] = '{30, 25};
  int  mxl, myl;
  bit  vbd, ov;
  bit  act[2], dead[2], mhit[2];
  int  mhp[2], inv_end[2];

  task automatic tick();
    exp_t e;
    bit ovn;
    int t;
    int ox, oy;
    t = cyc;
    ox = int'(obstacle_x);
    oy = int'(obstacle_y);
    if (rst) begin
      mxl = 0; myl = 0; vbd = 0; ov = 0;
      for (int k = 0; k < 2; k++) begin
        act[k] = 0; dead[k] = 0; inv_end[k] = 0;
        mhp[k] = hpm[k]; mhit[k] = 0;
      end
    end else begin
      ovn = (ox != 0 || oy != 0)
         && ox >= mxl && ox <= mxl + 15
         && oy >= myl && oy <= myl + 15;
      if (vblank && !vbd) begin
        mxl = int'(mouse_x);
        myl = int'(mouse_y);
      end
      vbd = vblank;
      for (int k = 0; k < 2; k++) begin
        mhit[k] = 0;
        if (!act[k]) begin
          act[k] = game_on;
          mhp[k] = hpm[k];
        end else if (!game_on) begin
          act[k] = 0; dead[k] = 0; inv_end[k] = 0;
          mhp[k] = hpm[k];
        end else if (dead[k] || t < inv_end[k]) begin
          mhit[k] = 0;
        end else if (ov) begin
          mhit[k] = 1;
          mhp[k] = (mhp[k] > DMGV) ? mhp[k] - DMGV : 0;
          if (mhp[k] == 0) dead[k] = 1;
          else inv_end[k] = t + 1 + INV;
        end
      end
      ov = ovn;
    end
    for (int k = 0; k < 2; k++) begin
      e.tag = t + 1;
      e.hit = mhit[k];
      e.hp  = 8'(mhp[k]);
      e.inv = act[k] && !dead[k] && (t + 1 < inv_end[k]);
      e.go  = act[k] && dead[k];
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(input int x, input int y, input int n);
    obstacle_x = 12'(x);
    obstacle_y = 12'(y);
    ticks(n);
    obstacle_x = '0;
    obstacle_y = '0;
  endtask

  task automatic latch(input int x, input int y);
    mouse_x = 12'(x);
    mouse_y = 12'(y);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  // Monitor: compare whichever expected entries are due this cycle.
  exp_t me;
  initial begin
    forever begin
      @(negedge pclk);
      if (q0.size() != 0 && q0[0].tag <= cyc) begin
        me = q0.pop_front();
        chk("tag0", 8'(me.tag == cyc), 8'd1);
        chk("hit0", {7'd0, hit0}, {7'd0, me.hit});
        chk("hp0", hp0, me.hp);
        chk("inv0", {7'd0, inv0}, {7'd0, me.inv});
        chk("go0", {7'd0, go0}, {7'd0, me.go});
      end
      if (q1.size() != 0 && q1[0].tag <= cyc) begin
        me = q1.pop_front();
        chk("hit1", {7'd0, hit1}, {7'd0, me.hit});
        chk("hp1", hp1, me.hp);
        chk("inv1", {7'd0, inv1}, {7'd0, me.inv});
        chk("go1", {7'd0, go1}, {7'd0, me.go});
      end
    end
  end

  initial begin
    int mx, my;
    ticks(3);
    rst = 1'b0;
    tick();
    game_on = 1'b1;
    ticks(2);
    latch(100, 200);
    pix(110, 210, 1);
    ticks(12);
    pix(115, 215, 1);
    ticks(12);
    pix(116, 210, 1);
    ticks(3);
    pix(99, 210, 1);
    ticks(3);
    pix(100, 216, 1);
    ticks(3);
    game_on = 1'b0;
    tick();
    game_on = 1'b1;
    ticks(2);
    latch(0, 0);
    pix(0, 0, 4);
    ticks(2);
    latch(100, 200);
    pix(108, 208, 40);
    ticks(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(3);
    mouse_x = 12'd300;
    mouse_y = 12'd300;
    ticks(2);
    pix(305, 305, 1);
    ticks(4);
    latch(300, 300);
    pix(305, 305, 1);
    ticks(4);
    game_on = 1'b0;
    tick();
    game_on = 1'b1;
    ticks(3);
    latch(4088, 4090);
    pix(4095, 4095, 1);
    ticks(3);
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      game_on = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 29) == 0) begin
        mx = (i % 3 == 0) ? int'($urandom_range(4070, 4095))
                          : int'($urandom_range(0, 4095));
        my = (i % 5 == 0) ? int'($urandom_range(0, 20))
                          : int'($urandom_range(0, 4095));
        mouse_x = 12'(mx);
        mouse_y = 12'(my);
      end
      vblank = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        obstacle_x = '0;
        obstacle_y = '0;
      end else begin
        obstacle_x = 12'(int'(mouse_x) + int'($urandom_range(0, 40)) - 12);
        obstacle_y = 12'(int'(mouse_y) + int'($urandom_range(0, 40)) - 12);
      end
      tick();
    end
    rst = 1'b0;
    vblank = 1'b0;
    obstacle_x = '0;
    obstacle_y = '0;
    ticks(3);
    @(negedge pclk);
    #1;
    checks++;
    if (q0.size() > 1 || q1.size() > 1) begin
      errors++;
      $display("FAIL drain got=%0d/%0d pending exp<=1", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
